// File: rtl/idma_axi_pkg.sv
// Shared AXI encodings and state type for the iDMA AXI blocks.
package idma_axi_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_slv_state_e;

endpackage

// File: rtl/axi_rd_slv_rbuf.sv
// Two-entry valid/ready skid buffer carrying R beats {id, data, resp, last}.
module axi_rd_slv_rbuf #(
  parameter int unsigned IDW = 4,
  parameter int unsigned DW  = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_valid,
  input  logic [IDW-1:0] wr_id,
  input  logic [DW-1:0]  wr_data,
  input  logic [1:0]     wr_resp,
  input  logic           wr_last,
  output logic           rvalid,
  input  logic           rready,
  output logic [IDW-1:0] rid,
  output logic [DW-1:0]  rdata,
  output logic [1:0]     rresp,
  output logic           rlast,
  output logic [1:0]     count
);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    logic [1:0]     resp;
    logic           last;
  } rbeat_t;

  rbeat_t slots [2];
  logic   wr_ptr, rd_ptr;
  logic   pop;

  assign pop    = rvalid & rready;
  assign rvalid = (count != 2'd0);
  assign rid    = slots[rd_ptr].id;
  assign rdata  = slots[rd_ptr].data;
  assign rresp  = slots[rd_ptr].resp;
  assign rlast  = slots[rd_ptr].last;

  // NOTE: the slots are reset because they drive the R outputs directly,
  // which must read zero while reset is asserted.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) slots[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr_valid) begin
        slots[wr_ptr] <= '{id: wr_id, data: wr_data, resp: wr_resp, last: wr_last};
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, wr_valid} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/axi_rd_slv.sv
// AXI3 read responder: queues AR requests and streams R beats from a 1-cycle-latency SRAM.
module axi_rd_slv
  import idma_axi_pkg::*;
#(
  parameter int unsigned AXI_IDW      = 4,
  parameter int unsigned AXI_DATA_WID = 256,
  parameter int unsigned AXI_STRBW    = AXI_DATA_WID / 8,
  parameter int unsigned AR_DEPTH     = 4,
  parameter int unsigned MEM_AW       = 12
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    i_arvalid,
  output logic                    o_arready,
  input  logic [AXI_IDW-1:0]      i_arid,
  input  logic [31:0]             i_araddr,
  input  logic [3:0]              i_arlen,
  input  logic [2:0]              i_arsize,
  input  logic [1:0]              i_arburst,
  output logic                    o_rvalid,
  input  logic                    i_rready,
  output logic [AXI_IDW-1:0]      o_rid,
  output logic [AXI_DATA_WID-1:0] o_rdata,
  output logic [1:0]              o_rresp,
  output logic                    o_rlast,
  output logic                    mem_rd_en,
  output logic [MEM_AW-1:0]       mem_rd_addr,
  input  logic [AXI_DATA_WID-1:0] mem_rd_data
);

  localparam int unsigned OFFW = $clog2(AXI_STRBW);
  localparam int unsigned PTRW = $clog2(AR_DEPTH);

  typedef struct packed {
    logic [AXI_IDW-1:0] id;
    logic [MEM_AW-1:0]  addr;
    logic [3:0]         len;
    logic               err;
  } ar_entry_t;

  // AR queue: pointer FIFO with an extra wrap bit to tell full from empty.
  ar_entry_t   ar_mem [AR_DEPTH];
  ar_entry_t   ar_in, ar_head;
  logic [PTRW:0] ar_wr_ptr, ar_rd_ptr;
  logic        ar_full, ar_empty, ar_push, ar_pop, arready_en;
  logic        unused_addr_bits;

  assign ar_empty  = (ar_wr_ptr == ar_rd_ptr);
  assign ar_full   = (ar_wr_ptr[PTRW] != ar_rd_ptr[PTRW]) &&
                     (ar_wr_ptr[PTRW-1:0] == ar_rd_ptr[PTRW-1:0]);
  assign o_arready = arready_en & ~ar_full;
  assign ar_push   = i_arvalid & o_arready;
  assign ar_head   = ar_mem[ar_rd_ptr[PTRW-1:0]];

  assign ar_in.id   = i_arid;
  assign ar_in.addr = i_araddr[MEM_AW+OFFW-1:OFFW];
  assign ar_in.len  = i_arlen;
  assign ar_in.err  = (i_arburst != BURST_INCR) || (i_arsize != 3'(OFFW));
  assign unused_addr_bits = ^{i_araddr[31:MEM_AW+OFFW], i_araddr[OFFW-1:0]};

  // NOTE: queue storage needs no reset; the pointers alone define its contents.
  always_ff @(posedge aclk) begin
    if (ar_push) ar_mem[ar_wr_ptr[PTRW-1:0]] <= ar_in;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ar_wr_ptr  <= '0;
      ar_rd_ptr  <= '0;
      arready_en <= 1'b0;
    end else begin
      arready_en <= 1'b1;
      if (ar_push) ar_wr_ptr <= ar_wr_ptr + 1'b1;
      if (ar_pop)  ar_rd_ptr <= ar_rd_ptr + 1'b1;
    end
  end

  rd_slv_state_e      state_q, state_d;
  logic [MEM_AW-1:0]  addr_q;
  logic [3:0]         beat_cnt_q;
  logic [AXI_IDW-1:0] id_q;
  logic               err_q;
  logic [1:0]         rbuf_count;
  logic               r_pop, credit, issue;
  logic               dl_valid, dl_last, dl_err, dl_rd;
  logic [AXI_IDW-1:0] dl_id;

  // A beat leaving the buffer this cycle frees its slot, so back-to-back
  // beats keep flowing while i_rready stays high.
  assign r_pop  = o_rvalid & i_rready;
  assign credit = (({1'b0, rbuf_count} + {2'b00, dl_valid}) - {2'b00, r_pop}) < 3'd2;
  assign issue  = (state_q == BURST) && credit;

  assign mem_rd_en   = issue & ~err_q;
  assign mem_rd_addr = addr_q;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    ar_pop  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!ar_empty) begin
          ar_pop  = 1'b1;
          state_d = BURST;
        end
      end
      BURST: begin
        if (issue && beat_cnt_q == 4'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      beat_cnt_q <= '0;
      id_q       <= '0;
      err_q      <= 1'b0;
      dl_valid   <= 1'b0;
      dl_id      <= '0;
      dl_last    <= 1'b0;
      dl_err     <= 1'b0;
      dl_rd      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ar_pop) begin
        addr_q     <= ar_head.addr;
        beat_cnt_q <= ar_head.len;
        id_q       <= ar_head.id;
        err_q      <= ar_head.err;
      end else if (issue) begin
        addr_q     <= addr_q + 1'b1;
        beat_cnt_q <= beat_cnt_q - 4'd1;
      end
      dl_valid <= issue;
      dl_id    <= id_q;
      dl_last  <= (beat_cnt_q == 4'd0);
      dl_err   <= err_q;
      dl_rd    <= issue & ~err_q;
    end
  end

  axi_rd_slv_rbuf #(
    .IDW (AXI_IDW),
    .DW  (AXI_DATA_WID)
  ) u_rbuf (
    .clk      (aclk),
    .rst_n    (aresetn),
    .wr_valid (dl_valid),
    .wr_id    (dl_id),
    .wr_data  (dl_rd ? mem_rd_data : '0),
    .wr_resp  (dl_err ? RESP_SLVERR : RESP_OKAY),
    .wr_last  (dl_last),
    .rvalid   (o_rvalid),
    .rready   (i_rready),
    .rid      (o_rid),
    .rdata    (o_rdata),
    .rresp    (o_rresp),
    .rlast    (o_rlast),
    .count    (rbuf_count)
  );

endmodule

// File: tb/tb_axi_rd_slv.sv
// Scoreboard bench for axi_rd_slv with a 1-cycle-latency SRAM model.
module tb_axi_rd_slv;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         i_arvalid = 1'b0;
  logic         o_arready;
  logic [3:0]   i_arid = '0;
  logic [31:0]  i_araddr = '0;
  logic [3:0]   i_arlen = '0;
  logic [2:0]   i_arsize = 3'd5;
  logic [1:0]   i_arburst = 2'b01;
  logic         o_rvalid;
  logic         i_rready = 1'b0;
  logic [3:0]   o_rid;
  logic [255:0] o_rdata;
  logic [1:0]   o_rresp;
  logic         o_rlast;
  logic         mem_rd_en;
  logic [11:0]  mem_rd_addr;
  logic [255:0] mem_rd_data = '0;

  axi_rd_slv dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .i_arvalid   (i_arvalid),
    .o_arready   (o_arready),
    .i_arid      (i_arid),
    .i_araddr    (i_araddr),
    .i_arlen     (i_arlen),
    .i_arsize    (i_arsize),
    .i_arburst   (i_arburst),
    .o_rvalid    (o_rvalid),
    .i_rready    (i_rready),
    .o_rid       (o_rid),
    .o_rdata     (o_rdata),
    .o_rresp     (o_rresp),
    .o_rlast     (o_rlast),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [3:0]   id;
    logic [255:0] data;
    logic [1:0]   resp;
    logic         last;
  } beat_t;

  beat_t       exp_q [$];
  logic [11:0] addr_q [$];
  int          issue_cyc_q [$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          hs_cyc = 0;
  int          issued = 0;
  int          popped = 0;
  bit          bp_chk = 1'b0;
  int          rready_mode = 0;  // 0: always ready, 1: toggle, 2: never ready

  function automatic logic [255:0] mem_word(input logic [11:0] a);
    return {8{32'hC0DE_0000 | {20'h0, a}}};
  endfunction

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // SRAM model: unread cycles return a non-zero pattern so error beats must zero it.
  always @(posedge aclk)
    mem_rd_data <= mem_rd_en ? mem_word(mem_rd_addr) : {8{32'hDEAD_BEEF}};

  always @(posedge aclk) cyc++;

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      case (rready_mode)
        0:       i_rready = 1'b1;
        1:       i_rready = ~i_rready;
        default: i_rready = 1'b0;
      endcase
    end
  end

  // Monitor: SRAM address order, R scoreboard, payload stability, occupancy bound.
  logic         stall_prev = 1'b0;
  logic [255:0] prev_data;
  logic [7:0]   prev_meta;
  always @(negedge aclk) begin : mon
    beat_t e;
    if (!aresetn) begin
      stall_prev = 1'b0;
    end else begin
      if (mem_rd_en) begin
        issued++;
        issue_cyc_q.push_back(cyc);
        if (addr_q.size() == 0) check("mem_rd_en_unexpected", 1, 0);
        else                    check("mem_rd_addr", mem_rd_addr, addr_q.pop_front());
      end
      if (stall_prev) begin
        check("hold_data", o_rdata, prev_data);
        check("hold_meta", {o_rvalid, o_rid, o_rresp, o_rlast}, prev_meta);
      end
      if (o_rvalid && i_rready) begin
        popped++;
        if (exp_q.size() == 0) check("r_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("rid", o_rid, e.id);
          check("rdata", o_rdata, e.data);
          check("rresp", o_rresp, e.resp);
          check("rlast", o_rlast, e.last);
        end
      end
      if (bp_chk && mem_rd_en) check("held_le2", (issued - popped) <= 2, 1);
      stall_prev = o_rvalid && !i_rready;
      prev_data  = o_rdata;
      prev_meta  = {o_rvalid, o_rid, o_rresp, o_rlast};
    end
  end

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input int budget, output bit ok);
    int          waited;
    bit          err;
    logic [11:0] w;
    beat_t       b;
    waited = 0;
    ok     = 1'b0;
    @(posedge aclk);
    #1;
    i_arvalid = 1'b1;
    i_arid    = id;
    i_araddr  = addr;
    i_arlen   = len;
    i_arburst = burst;
    i_arsize  = 3'd5;
    while (!ok && waited < budget) begin
      @(negedge aclk);
      if (o_arready) begin
        ok     = 1'b1;
        hs_cyc = cyc;
        err    = (burst != 2'b01);
        w      = addr[16:5];
        for (int i = 0; i <= int'(len); i++) begin
          b.id   = id;
          b.data = err ? '0 : mem_word(w);
          b.resp = err ? 2'b10 : 2'b00;
          b.last = (i == int'(len));
          exp_q.push_back(b);
          if (!err) addr_q.push_back(w);
          w = w + 12'd1;
        end
      end else begin
        waited++;
      end
    end
    @(posedge aclk);
    #1;
    i_arvalid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || addr_q.size() != 0) && w < budget) begin
      @(negedge aclk);
      w++;
    end
    repeat (3) @(negedge aclk);
    check({"drain_", tag}, exp_q.size() + addr_q.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit ok;
    int w;
    int acc;
    int p0;

    // Reset values
    #12;
    check("rst_arready", o_arready, 0);
    check("rst_rvalid", o_rvalid, 0);
    check("rst_rlast", o_rlast, 0);
    check("rst_rresp", o_rresp, 0);
    check("rst_rid", o_rid, 0);
    check("rst_rdata", o_rdata, 0);
    check("rst_mem_rd_en", mem_rd_en, 0);
    check("rst_mem_rd_addr", mem_rd_addr, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("arready_after_rst", o_arready, 1);

    // Single burst: words 2..5, fixed latency, consecutive issue
    rready_mode = 0;
    issue_cyc_q.delete();
    send_ar(4'd5, 32'h40, 4'd3, 2'b01, 20, ok);
    check("ar_single_ok", ok, 1);
    w = 0;
    while (!o_rvalid && w < 10) begin
      @(negedge aclk);
      w++;
    end
    check("first_rvalid_latency", cyc - hs_cyc, 4);
    wait_drain("single", 50);
    check("single_issue_count", issue_cyc_q.size(), 4);
    if (issue_cyc_q.size() == 4) begin
      check("first_issue_latency", issue_cyc_q[0] - hs_cyc, 2);
      for (int i = 1; i < 4; i++) check("issue_consecutive", issue_cyc_q[i] - issue_cyc_q[i-1], 1);
    end

    // Backpressure: 16 beats with i_rready toggling
    issued = 0;
    popped = 0;
    bp_chk = 1'b1;
    rready_mode = 1;
    send_ar(4'd7, 32'h1000, 4'd15, 2'b01, 20, ok);
    check("ar_bp_ok", ok, 1);
    wait_drain("backpressure", 200);
    check("bp_beats", popped, 16);
    bp_chk = 1'b0;

    // Outstanding: with R stalled, capacity is 2 held beats + 1 burst in the
    // FSM + a full AR queue, so the 8th request must wait for the drain.
    rready_mode = 2;
    acc = 0;
    for (int i = 1; i <= 8; i++) begin
      send_ar(4'(i), 32'(i) << 5, 4'd0, 2'b01, 15, ok);
      if (ok) acc++;
    end
    check("outstanding_accepted", acc, 7);
    rready_mode = 0;
    send_ar(4'd8, 32'd8 << 5, 4'd0, 2'b01, 50, ok);
    check("outstanding_8th_ok", ok, 1);
    wait_drain("outstanding", 100);

    // Error burst: FIXED burst type
    issue_cyc_q.delete();
    send_ar(4'd2, 32'h300, 4'd2, 2'b00, 20, ok);
    check("ar_err_ok", ok, 1);
    wait_drain("error", 50);
    check("err_no_mem_rd", issue_cyc_q.size(), 0);

    // Address wrap from word 0xFFE
    send_ar(4'd4, 32'h1FFC0, 4'd3, 2'b01, 20, ok);
    check("ar_wrap_ok", ok, 1);
    wait_drain("wrap", 50);

    // Reset mid-burst
    send_ar(4'd9, 32'h100, 4'd7, 2'b01, 20, ok);
    check("ar_rst_ok", ok, 1);
    w = 0;
    while (!o_rvalid && w < 10) begin
      @(negedge aclk);
      w++;
    end
    @(posedge aclk);
    #2;
    aresetn = 1'b0;
    exp_q.delete();
    addr_q.delete();
    #1;
    check("midrst_rvalid", o_rvalid, 0);
    check("midrst_mem_rd_en", mem_rd_en, 0);
    check("midrst_arready", o_arready, 0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    p0 = popped;
    send_ar(4'd3, 32'h200, 4'd0, 2'b01, 20, ok);
    check("ar_post_rst_ok", ok, 1);
    wait_drain("post_reset", 50);
    repeat (10) @(negedge aclk);
    check("post_reset_beats", popped - p0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
